// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: builds a start/data/parity/stop frame and paces an 11-bit MSB-first PISO.
// Define UART_TX_PARITY_EN to put even parity in frame bit 1; otherwise bit 1 is a second stop bit.
module uart_tx_ctrl #(
    parameter int DW       = 11,
    parameter int BAUD_DIV = 5208
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    tx_data,
    input  logic          tx_start,
    output logic          tx_ready,
    output logic          tx_done,
    output logic [DW-1:0] piso_data,
    output logic          piso_enb,
    output logic          piso_load,
    output logic          piso_shift,
    output logic          piso_fsm_reset
);
    localparam int            BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_reg;
    logic [BW-1:0] baud_cnt_reg;
    logic [3:0]    bit_cnt_reg;
    logic [DW-1:0] frame_reg;

    logic [7:0]    data_rev;
    logic          parity_bit;
    logic [DW-1:0] frame_next;
    logic          baud_tc;

    // The PISO shifts MSB-first, so the byte is bit-reversed to leave the line LSB-first.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rev
            assign data_rev[7-gi] = tx_data[gi];
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    assign parity_bit = ^tx_data;
`else
    assign parity_bit = 1'b1;
`endif

    assign frame_next = {1'b0, data_rev, parity_bit, 1'b1};
    assign baud_tc    = (baud_cnt_reg == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            frame_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (tx_start) begin
                        frame_reg <= frame_next;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    baud_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    state_reg    <= SEND;
                end
                SEND: begin
                    if (baud_tc) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg < BIT_LAST) begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else begin
                            state_reg <= DONE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The last bit period ends without a shift; the line returns high via fsm_reset in DONE.
    assign tx_ready       = (state_reg == IDLE);
    assign tx_done        = (state_reg == DONE);
    assign piso_load      = (state_reg == LOAD);
    assign piso_shift     = (state_reg == SEND) && baud_tc && (bit_cnt_reg < BIT_LAST);
    assign piso_enb       = piso_load | piso_shift;
    assign piso_fsm_reset = (state_reg != SEND);
    assign piso_data      = frame_reg;

endmodule
